// File: rtl/reg_ctrl_master_if.sv
// Register-control master bundle: command port, slave bus and response port.
// The master modport is the initiator's view. The slave modport is the view of
// whatever sits around it: the command source, the register slave and the
// response sink.
interface reg_ctrl_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    // command port
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // slave bus
    logic [ADDR_WIDTH-1:0] addr;
    logic                  sel;
    logic                  wr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    // response port
    logic                  rsp_valid;
    logic                  rsp_wr;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [15:0]           txn_count;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rdata, ready,
        output cmd_ready, addr, sel, wr, wdata,
        output rsp_valid, rsp_wr, rsp_err, rsp_rdata, txn_count
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rdata, ready,
        input  cmd_ready, addr, sel, wr, wdata,
        input  rsp_valid, rsp_wr, rsp_err, rsp_rdata, txn_count
    );
endinterface

// File: rtl/reg_ctrl_master.sv
// Register-control bus initiator.
// This block takes one command at a time from a valid/ready port and drives
// it onto the addr/sel/wr/wdata slave bus. For reads it captures rdata on the
// closing edge of the RDATA cycle. Each finished or timed-out transaction is
// reported with a one-cycle rsp_valid strobe.
// All outputs are registered. cmd_ready is the only exception: it is decoded
// directly from the state, so a new command can be accepted in the same cycle
// that rsp_valid is high.
module reg_ctrl_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk,
    input  logic                rst,
    reg_ctrl_master_if.master   bus
);

    // The timeout counter only has to hold 0..TIMEOUT. It saturates.
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  addr_r, addr_s;
    logic                   wr_r, wr_s;
    logic [DATA_WIDTH-1:0]  wdata_r, wdata_s;
    logic                   sel_r, sel_s;
    logic [TO_W-1:0]        to_cnt_r, to_cnt_s;
    logic                   rsp_valid_r, rsp_valid_s;
    logic                   rsp_wr_r, rsp_wr_s;
    logic                   rsp_err_r, rsp_err_s;
    logic [DATA_WIDTH-1:0]  rsp_rdata_r, rsp_rdata_s;
    logic [15:0]            txn_cnt_r, txn_cnt_s;

    // FSM state register; the async reset abandons any transaction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Bus, response and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r      <= {ADDR_WIDTH{1'b0}};
            wr_r        <= 1'b0;
            wdata_r     <= {DATA_WIDTH{1'b0}};
            sel_r       <= 1'b0;
            to_cnt_r    <= {TO_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_wr_r    <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {DATA_WIDTH{1'b0}};
            txn_cnt_r   <= 16'h0000;
        end else begin
            addr_r      <= addr_s;
            wr_r        <= wr_s;
            wdata_r     <= wdata_s;
            sel_r       <= sel_s;
            to_cnt_r    <= to_cnt_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_wr_r    <= rsp_wr_s;
            rsp_err_r   <= rsp_err_s;
            rsp_rdata_r <= rsp_rdata_s;
            txn_cnt_r   <= txn_cnt_s;
        end
    end

    // Next-state and next-output decode; everything holds unless a transition updates it
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        wr_s        = wr_r;
        wdata_s     = wdata_r;
        sel_s       = sel_r;
        to_cnt_s    = to_cnt_r;
        rsp_valid_s = 1'b0;
        rsp_wr_s    = rsp_wr_r;
        rsp_err_s   = rsp_err_r;
        rsp_rdata_s = rsp_rdata_r;
        txn_cnt_s   = txn_cnt_r;

        case (state_r)
            IDLE: begin
                if (bus.cmd_valid) begin
                    // Latch the command. The bus goes active from the next cycle.
                    addr_s   = bus.cmd_addr;
                    wr_s     = bus.cmd_wr;
                    wdata_s  = bus.cmd_wdata;
                    sel_s    = 1'b1;
                    to_cnt_s = {TO_W{1'b0}};
                    state_s  = ISSUE;
                end else begin
                    sel_s    = 1'b0;
                end
            end

            ISSUE: begin
                if (bus.ready) begin
                    if (wr_r) begin
                        // The slave stored the data on this edge.
                        sel_s       = 1'b0;
                        wr_s        = 1'b0;
                        rsp_valid_s = 1'b1;
                        rsp_wr_s    = 1'b1;
                        rsp_err_s   = 1'b0;
                        rsp_rdata_s = {DATA_WIDTH{1'b0}};
                        txn_cnt_s   = txn_cnt_r + 16'd1;
                        state_s     = IDLE;
                    end else begin
                        // Keep sel high through RDATA so the slave can raise ready again.
                        state_s     = RDATA;
                    end
                end else begin
                    if (to_cnt_r != TO_MAX) begin
                        to_cnt_s = to_cnt_r + TO_W'(1);
                    end else begin
                        to_cnt_s = to_cnt_r;
                    end
                    if (to_cnt_r == TO_LAST) begin
                        // This edge is the TIMEOUT-th consecutive one with ready low.
                        sel_s       = 1'b0;
                        wr_s        = 1'b0;
                        rsp_valid_s = 1'b1;
                        rsp_wr_s    = wr_r;
                        rsp_err_s   = 1'b1;
                        rsp_rdata_s = {DATA_WIDTH{1'b0}};
                        state_s     = IDLE;
                    end else begin
                        state_s     = ISSUE;
                    end
                end
            end

            RDATA: begin
                rsp_rdata_s = bus.rdata;
                rsp_valid_s = 1'b1;
                rsp_wr_s    = 1'b0;
                rsp_err_s   = 1'b0;
                sel_s       = 1'b0;
                wr_s        = 1'b0;
                txn_cnt_s   = txn_cnt_r + 16'd1;
                state_s     = IDLE;
            end

            default: begin
                sel_s   = 1'b0;
                wr_s    = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready = (state_r == IDLE);
    assign bus.addr      = addr_r;
    assign bus.sel       = sel_r;
    assign bus.wr        = wr_r;
    assign bus.wdata     = wdata_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_wr    = rsp_wr_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.txn_count = txn_cnt_r;

endmodule

// File: doc/reg_ctrl_master.md
Name: reg_ctrl_master

Overview:
Bus initiator for the register-control slave interface (addr/sel/wr/wdata/rdata/ready). It accepts single register commands on a valid/ready command port and drives each one onto the slave bus. For reads it captures the returned data, and it reports every completed or timed-out transaction on a one-cycle response strobe. It sits between testbench/CPU-side sequencing logic and a register-control slave instance.

Parameters:
ADDR_WIDTH, 8, slave address width
DATA_WIDTH, 16, slave data width
TIMEOUT, 16, max consecutive cycles ready may stay low in ISSUE before abort (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at rising edge
cmd_wr  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  target address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
addr  out  ADDR_WIDTH  slave address
sel  out  1  slave select
wr  out  1  slave write enable
wdata  out  DATA_WIDTH  slave write data
rdata  in  DATA_WIDTH  slave read data
ready  in  1  slave ready
rsp_valid  out  1  one-cycle strobe, transaction finished
rsp_wr  out  1  finished transaction was a write
rsp_err  out  1  finished by timeout
rsp_rdata  out  DATA_WIDTH  captured read data (0 for writes/errors)
txn_count  out  16  count of error-free completed transactions, wraps at 0xFFFF->0

Behaviour:
- All outputs registered except cmd_ready = (state==IDLE).
- Reset (async, immediate): state=IDLE, sel=0, wr=0, addr=0, wdata=0, rsp_valid=0, rsp_wr=0, rsp_err=0, rsp_rdata=0, txn_count=0, timeout counter=0.
- Reset mid-transaction: sel drops asynchronously. The transaction is lost and no response is issued.
- FSM states: IDLE, ISSUE, RDATA.
- IDLE: sel=0. On accept, latch cmd_addr/cmd_wr/cmd_wdata into addr/wr/wdata, set sel=1, clear timeout counter, go to ISSUE. Bus is active from the cycle after accept.
- ISSUE, edge with ready=1, write: the slave stores on this edge. Next cycle: sel=0, wr=0, rsp_valid=1, rsp_wr=1, rsp_err=0, rsp_rdata=0, txn_count+1, state IDLE.
- ISSUE, edge with ready=1, read: the slave accepts on this edge and drops ready next cycle. Go to RDATA with sel held 1 and wr=0. sel must stay high in RDATA so the slave restores ready.
- RDATA: one cycle. On its closing edge capture rdata into rsp_rdata. Next cycle: rsp_valid=1, rsp_wr=0, rsp_err=0, sel=0, txn_count+1, state IDLE. No timeout check in RDATA.
- ISSUE, edge with ready=0: increment timeout counter. When the counter reaches TIMEOUT (ready low for TIMEOUT consecutive edges):
  - next cycle sel=0, wr=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, rsp_wr=latched wr;
  - txn_count unchanged; state IDLE.
- Minimum command spacing: write 2 cycles (accept/IDLE, ISSUE), read 3 cycles (IDLE, ISSUE, RDATA), response strobe coincides with the following IDLE. A new command may be accepted in the same cycle rsp_valid is high.
- rsp_valid is high for exactly one cycle per accepted command, except when reset intervenes. There is no response backpressure.
- addr/wdata/wr remain stable for the whole time sel=1.
- cmd_* inputs are ignored outside IDLE.
- Timeout counter width is clog2(TIMEOUT+1). It saturates; it cannot wrap.

Test Plan:
- Reset then read addr 0x10 against slave with RESET_VAL=16'h1234 -> rsp_valid one pulse, rsp_wr=0, rsp_err=0, rsp_rdata=0x1234, txn_count=1; sel high exactly 2 cycles.
- Write 0x10<=0xBEEF, then read 0x10 -> write rsp (rsp_wr=1, rsp_rdata=0) 2 cycles after accept; read returns 0xBEEF; txn_count=2.
- Back-to-back with cmd_valid held: W 0x01<=0xAAAA, R 0x01, W 0x02<=0x5555, R 0x02 -> accepts spaced 2/3/2 cycles; reads return 0xAAAA then 0x5555; slave ready high again before each ISSUE.
- Slave model forcing ready=0, TIMEOUT=4, read issued -> sel high 4 cycles, then rsp_valid with rsp_err=1, rsp_rdata=0; txn_count unchanged; cmd_ready high next cycle.
- Assert rst while in RDATA -> sel=0 in the same cycle (async), no rsp_valid, txn_count=0; a following write completes normally.
- Preload txn_count to 0xFFFF via 65535 writes, then one more write -> txn_count wraps to 0x0000, rsp_err=0.
